// File: rtl/sv32_page_walker.sv
// Sv32 hardware page-table walker: one- or two-level PTE fetch over a
// single-outstanding read port, with a registered one-cycle result broadcast.
module sv32_page_walker #(
  parameter int PADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IN_rqValid,
  input  logic [31:0]        IN_rqVAddr,
  output logic               OUT_rqReady,
  input  logic [19:0]        IN_satpPPN,
  input  logic               IN_flush,
  output logic               OUT_pwActive,
  output logic               OUT_memValid,
  output logic [PADDR_W-1:0] OUT_memAddr,
  input  logic               IN_memReady,
  input  logic               IN_memRespValid,
  input  logic [31:0]        IN_memRespData,
  output logic               OUT_resValid,
  output logic [19:0]        OUT_resVPN,
  output logic [19:0]        OUT_resPPN,
  output logic               OUT_resIsSuperPage,
  output logic [7:0]         OUT_resPerm,
  output logic               OUT_resPageFault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ1,
    S_WAIT1,
    S_REQ2,
    S_WAIT2,
    S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [19:0] r_vpn;
  logic [19:0] r_base;

  logic        r_res_valid;
  logic [19:0] r_res_vpn;
  logic [19:0] r_res_ppn;
  logic        r_res_super;
  logic [7:0]  r_res_perm;
  logic        r_res_fault;

  logic        w_accept;
  logic        w_pte_bad;
  logic        w_pte_leaf;
  logic        w_pte_misaligned;
  logic        w_res_fire;
  logic        w_res_fault;
  logic        w_res_super;
  logic        w_take_base;
  logic [19:0] w_addr_ppn;
  logic [9:0]  w_addr_idx;
  logic [31:0] w_addr_full;
  logic        w_unused_rsw;

  assign OUT_pwActive = (r_state != S_IDLE);
  assign OUT_rqReady  = (r_state == S_IDLE) && !IN_flush;
  assign w_accept     = IN_rqValid && OUT_rqReady;

  // Reserved encodings: invalid, W without R, or PPN bits beyond 32-bit physical space.
  assign w_pte_bad        = !IN_memRespData[0] || (IN_memRespData[2:1] == 2'b10) ||
                            (IN_memRespData[31:30] != 2'b00);
  assign w_pte_leaf       = IN_memRespData[3] | IN_memRespData[1];
  assign w_pte_misaligned = (IN_memRespData[19:10] != 10'd0);
  assign w_unused_rsw     = ^IN_memRespData[9:8];

  assign w_addr_full = {w_addr_ppn, w_addr_idx, 2'b00};
  assign OUT_memAddr = PADDR_W'(w_addr_full);

  always_comb begin
    w_state_next = r_state;
    w_res_fire   = 1'b0;
    w_res_fault  = 1'b0;
    w_res_super  = 1'b0;
    w_take_base  = 1'b0;
    OUT_memValid = 1'b0;
    w_addr_ppn   = r_base;
    w_addr_idx   = r_vpn[9:0];
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_REQ1;
      end
      S_REQ1: begin
        OUT_memValid = 1'b1;
        w_addr_ppn   = IN_satpPPN;
        w_addr_idx   = r_vpn[19:10];
        if (IN_flush)         w_state_next = IN_memReady ? S_DROP : S_IDLE;
        else if (IN_memReady) w_state_next = S_WAIT1;
      end
      S_REQ2: begin
        OUT_memValid = 1'b1;
        if (IN_flush)         w_state_next = IN_memReady ? S_DROP : S_IDLE;
        else if (IN_memReady) w_state_next = S_WAIT2;
      end
      S_WAIT1: begin
        if (IN_flush) begin
          // A response in the flush cycle completes the transfer; otherwise it is still owed.
          w_state_next = IN_memRespValid ? S_IDLE : S_DROP;
        end else if (IN_memRespValid) begin
          if (!w_pte_bad && !w_pte_leaf) begin
            w_take_base  = 1'b1;
            w_state_next = S_REQ2;
          end else begin
            w_res_fire   = 1'b1;
            w_res_fault  = w_pte_bad || w_pte_misaligned;
            w_res_super  = !w_res_fault;
            w_state_next = S_IDLE;
          end
        end
      end
      S_WAIT2: begin
        if (IN_flush) begin
          w_state_next = IN_memRespValid ? S_IDLE : S_DROP;
        end else if (IN_memRespValid) begin
          w_res_fire   = 1'b1;
          w_res_fault  = w_pte_bad || !w_pte_leaf;
          w_state_next = S_IDLE;
        end
      end
      S_DROP: begin
        if (IN_memRespValid) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vpn       <= '0;
      r_base      <= '0;
      r_res_valid <= 1'b0;
      r_res_vpn   <= '0;
      r_res_ppn   <= '0;
      r_res_super <= 1'b0;
      r_res_perm  <= '0;
      r_res_fault <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_res_valid <= w_res_fire;
      if (w_accept)    r_vpn  <= IN_rqVAddr[31:12];
      if (w_take_base) r_base <= IN_memRespData[29:10];
      if (w_res_fire) begin
        r_res_vpn   <= r_vpn;
        r_res_super <= w_res_super;
        r_res_fault <= w_res_fault;
        r_res_ppn   <= w_res_fault ? 20'd0 : IN_memRespData[29:10];
        r_res_perm  <= w_res_fault ? 8'd0  : IN_memRespData[7:0];
      end
    end
  end

  // A response is only legal while one is owed.
  always_ff @(posedge clk) begin
    if (!rst && IN_memRespValid)
      assert (r_state == S_WAIT1 || r_state == S_WAIT2 || r_state == S_DROP);
  end

  assign OUT_resValid       = r_res_valid;
  assign OUT_resVPN         = r_res_vpn;
  assign OUT_resPPN         = r_res_ppn;
  assign OUT_resIsSuperPage = r_res_super;
  assign OUT_resPerm        = r_res_perm;
  assign OUT_resPageFault   = r_res_fault;

endmodule

// File: tb/tb_sv32_page_walker.sv
module tb_sv32_page_walker;
  logic        clk = 1'b0;
  logic        rst;
  logic        IN_rqValid;
  logic [31:0] IN_rqVAddr;
  logic        OUT_rqReady;
  logic [19:0] IN_satpPPN;
  logic        IN_flush;
  logic        OUT_pwActive;
  logic        OUT_memValid;
  logic [31:0] OUT_memAddr;
  logic        IN_memReady;
  logic        IN_memRespValid;
  logic [31:0] IN_memRespData;
  logic        OUT_resValid;
  logic [19:0] OUT_resVPN;
  logic [19:0] OUT_resPPN;
  logic        OUT_resIsSuperPage;
  logic [7:0]  OUT_resPerm;
  logic        OUT_resPageFault;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sv32_page_walker #(.PADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .IN_rqValid        (IN_rqValid),
    .IN_rqVAddr        (IN_rqVAddr),
    .OUT_rqReady       (OUT_rqReady),
    .IN_satpPPN        (IN_satpPPN),
    .IN_flush          (IN_flush),
    .OUT_pwActive      (OUT_pwActive),
    .OUT_memValid      (OUT_memValid),
    .OUT_memAddr       (OUT_memAddr),
    .IN_memReady       (IN_memReady),
    .IN_memRespValid   (IN_memRespValid),
    .IN_memRespData    (IN_memRespData),
    .OUT_resValid      (OUT_resValid),
    .OUT_resVPN        (OUT_resVPN),
    .OUT_resPPN        (OUT_resPPN),
    .OUT_resIsSuperPage(OUT_resIsSuperPage),
    .OUT_resPerm       (OUT_resPerm),
    .OUT_resPageFault  (OUT_resPageFault)
  );

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    int          naccess;
    logic        fault;
    logic        sup;
    logic [19:0] ppn;
    logic [7:0]  perm;
  } exp_t;

  task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_fail++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic pte_bad(input logic [31:0] p);
    return (p[0] == 1'b0) || (p[2:1] == 2'b10) || (p[31:30] != 2'b00);
  endfunction

  function automatic logic pte_leaf(input logic [31:0] p);
    return p[1] || p[3];
  endfunction

  function automatic exp_t model(input logic [19:0] satp, input logic [31:0] va,
                                 input logic [31:0] p1, input logic [31:0] p2);
    exp_t e;
    e.a1 = {12'd0, satp} * 32'd4096 + (va >> 22) * 32'd4;
    e.a2 = 32'd0;
    e.naccess = 1;
    e.fault = 1'b1;
    e.sup = 1'b0;
    e.ppn = 20'd0;
    e.perm = 8'd0;
    if (pte_bad(p1)) return e;
    if (pte_leaf(p1)) begin
      if (p1[19:10] == 10'd0) begin
        e.fault = 1'b0;
        e.sup   = 1'b1;
        e.ppn   = p1[29:10];
        e.perm  = p1[7:0];
      end
      return e;
    end
    e.naccess = 2;
    e.a2 = {12'd0, p1[29:10]} * 32'd4096 + ((va >> 12) & 32'h3FF) * 32'd4;
    if (!pte_bad(p2) && pte_leaf(p2)) begin
      e.fault = 1'b0;
      e.ppn   = p2[29:10];
      e.perm  = p2[7:0];
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_pte(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0:       return r;
      1:       return {2'b00, r[29:10], r[9:4], 4'b0001};
      2:       return {2'b00, r[29:20], 10'd0, r[9:8], r[7:0] | 8'h03};
      3:       return {2'b00, r[29:10], r[9:8], r[7:0] | 8'h09};
      default: return {2'b00, r[29:1], 1'b1};
    endcase
  endfunction

  task automatic start_req(input logic [31:0] va);
    n_cmp++;
    if (OUT_rqReady !== 1'b1) fail("rqReady", OUT_rqReady, 1'b1);
    IN_rqValid = 1'b1;
    IN_rqVAddr = va;
    @(negedge clk);
    IN_rqValid = 1'b0;
  endtask

  task automatic serve(input logic [31:0] va, input logic [31:0] p1, input logic [31:0] p2,
                       input int rdy_wait, input int rsp_wait);
    exp_t        e;
    int          hs, rw, pend, cyc;
    bit          done;
    logic [31:0] exp_addr;
    int          exp_lat;
    e = model(IN_satpPPN, va, p1, p2);
    hs = 0; rw = 0; pend = -1; cyc = 1; done = 1'b0;
    while (!done && cyc < 100) begin
      IN_memReady = 1'b0;
      IN_memRespValid = 1'b0;
      IN_memRespData = 32'd0;
      if (OUT_resValid) begin
        done = 1'b1;
      end else begin
        n_cmp++;
        if ({OUT_pwActive, OUT_rqReady} !== 2'b10) fail("busy", {OUT_pwActive, OUT_rqReady}, 2'b10);
        if (OUT_memValid) begin
          exp_addr = (hs == 0) ? e.a1 : e.a2;
          n_cmp++;
          if (OUT_memAddr !== exp_addr) fail("memAddr", OUT_memAddr, exp_addr);
          if (rw < rdy_wait) rw++;
          else begin
            IN_memReady = 1'b1;
            hs++;
            rw = 0;
            pend = rsp_wait;
          end
        end else if (pend == 0) begin
          IN_memRespValid = 1'b1;
          IN_memRespData = (hs == 1) ? p1 : p2;
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++;
    if (done !== 1'b1) fail("result_seen", done, 1'b1);
    if (done) begin
      exp_lat = e.naccess * (2 + rdy_wait + rsp_wait) + 1;
      n_cmp++;
      if (cyc !== exp_lat) fail("latency", cyc, exp_lat);
      n_cmp++;
      if (hs !== e.naccess) fail("accesses", hs, e.naccess);
      n_cmp++;
      if (OUT_resVPN !== va[31:12]) fail("vpn", OUT_resVPN, va[31:12]);
      n_cmp++;
      if (OUT_resPageFault !== e.fault) fail("fault", OUT_resPageFault, e.fault);
      n_cmp++;
      if (OUT_resPPN !== e.ppn) fail("ppn", OUT_resPPN, e.ppn);
      n_cmp++;
      if (OUT_resPerm !== e.perm) fail("perm", OUT_resPerm, e.perm);
      if (!e.fault) begin
        n_cmp++;
        if (OUT_resIsSuperPage !== e.sup) fail("super", OUT_resIsSuperPage, e.sup);
      end
      $display("walk va=%08h p1=%08h p2=%08h -> ppn=%05h perm=%02h super=%0d fault=%0d",
               va, p1, p2, OUT_resPPN, OUT_resPerm, OUT_resIsSuperPage, OUT_resPageFault);
    end
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    n_cmp++;
    if ({OUT_resValid, OUT_pwActive, OUT_memValid} !== 3'b000)
      fail(tag, {OUT_resValid, OUT_pwActive, OUT_memValid}, 3'b000);
  endtask

  task automatic chk_fault(input string tag);
    n_cmp++;
    if ({OUT_resPageFault, OUT_resPPN, OUT_resPerm} !== {1'b1, 28'd0})
      fail(tag, {OUT_resPageFault, OUT_resPPN, OUT_resPerm}, {1'b1, 28'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] va, p1, p2;
    rst = 1'b1;
    IN_rqValid = 1'b0;
    IN_rqVAddr = 32'd0;
    IN_satpPPN = 20'h00080;
    IN_flush = 1'b0;
    IN_memReady = 1'b0;
    IN_memRespValid = 1'b0;
    IN_memRespData = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({OUT_memValid, OUT_resValid, OUT_pwActive, OUT_rqReady} !== 4'b0001)
      fail("rst_ctrl", {OUT_memValid, OUT_resValid, OUT_pwActive, OUT_rqReady}, 4'b0001);
    n_cmp++;
    if ({OUT_resVPN, OUT_resPPN, OUT_resPerm, OUT_resIsSuperPage, OUT_resPageFault} !== 50'd0)
      fail("rst_fields", {OUT_resVPN, OUT_resPPN, OUT_resPerm, OUT_resIsSuperPage, OUT_resPageFault}, 50'd0);

    start_req(32'h40001234);
    serve(32'h40001234, 32'h00024001, 32'h000400CF, 0, 0);
    n_cmp++;
    if (OUT_resPPN !== 20'h00100) fail("two_level_ppn", OUT_resPPN, 20'h00100);
    n_cmp++;
    if (OUT_resPerm !== 8'hCF) fail("two_level_perm", OUT_resPerm, 8'hCF);
    idle_after("two_level_once");

    start_req(32'h40001234);
    serve(32'h40001234, 32'h2000000F, 32'h0, 0, 0);
    n_cmp++;
    if ({OUT_resIsSuperPage, OUT_resPPN} !== {1'b1, 20'h80000})
      fail("super_ppn", {OUT_resIsSuperPage, OUT_resPPN}, {1'b1, 20'h80000});
    idle_after("super_once");

    start_req(32'h40001234);
    serve(32'h40001234, 32'h2000040F, 32'h0, 0, 0);
    chk_fault("misaligned");
    idle_after("misaligned_once");
    start_req(32'h40001234);
    serve(32'h40001234, 32'h00000000, 32'h0, 0, 0);
    chk_fault("invalid_l1");
    idle_after("invalid_once");
    start_req(32'h40001234);
    serve(32'h40001234, 32'h00024001, 32'h00024001, 0, 0);
    chk_fault("pointer_l0");
    idle_after("pointer_once");
    start_req(32'h40001234);
    serve(32'h40001234, 32'h00000005, 32'h0, 0, 0);
    chk_fault("w_only");
    idle_after("w_only_once");

    start_req(32'h40001234);
    serve(32'h40001234, 32'h2000000F, 32'h0, 5, 0);
    idle_after("backpressure_once");

    start_req(32'h40001234);
    IN_memReady = 1'b1;
    @(negedge clk);
    IN_memReady = 1'b0;
    IN_flush = 1'b1;
    n_cmp++;
    if (OUT_pwActive !== 1'b1) fail("flush_w1_active", OUT_pwActive, 1'b1);
    @(negedge clk);
    IN_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({OUT_pwActive, OUT_memValid, OUT_resValid} !== 3'b100)
        fail("flush_w1_drop", {OUT_pwActive, OUT_memValid, OUT_resValid}, 3'b100);
      if (i == 2) begin
        IN_memRespValid = 1'b1;
        IN_memRespData = 32'h000400CF;
      end
      @(negedge clk);
    end
    IN_memRespValid = 1'b0;
    n_cmp++;
    if ({OUT_pwActive, OUT_resValid, OUT_rqReady} !== 3'b001)
      fail("flush_w1_idle", {OUT_pwActive, OUT_resValid, OUT_rqReady}, 3'b001);
    start_req(32'h00400000);
    serve(32'h00400000, 32'h00024001, 32'h000400CF, 0, 0);
    idle_after("after_flush_once");

    start_req(32'h40001234);
    IN_memReady = 1'b1;
    @(negedge clk);
    IN_memReady = 1'b0;
    IN_memRespValid = 1'b1;
    IN_memRespData = 32'h00024001;
    @(negedge clk);
    IN_memRespValid = 1'b0;
    n_cmp++;
    if ({OUT_memValid, OUT_memAddr} !== {1'b1, 32'h00090004})
      fail("req2_addr", {OUT_memValid, OUT_memAddr}, {1'b1, 32'h00090004});
    IN_flush = 1'b1;
    @(negedge clk);
    IN_flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({OUT_pwActive, OUT_memValid, OUT_resValid} !== 3'b000)
        fail("flush_r2_quiet", {OUT_pwActive, OUT_memValid, OUT_resValid}, 3'b000);
      @(negedge clk);
    end

    start_req(32'h40001234);
    serve(32'h40001234, 32'h2000000F, 32'h0, 0, 0);
    n_cmp++;
    if (OUT_pwActive !== 1'b0) fail("b2b_result_cycle", OUT_pwActive, 1'b0);
    start_req(32'h00400000);
    serve(32'h00400000, 32'h00024001, 32'h000400CF, 0, 0);
    idle_after("b2b_done");

    for (int t = 0; t < 30; t++) begin
      IN_satpPPN = 20'($urandom);
      va = $urandom;
      p1 = gen_pte($urandom_range(0, 4));
      p2 = gen_pte($urandom_range(0, 4));
      start_req(va);
      serve(va, p1, p2, $urandom_range(0, 2), $urandom_range(0, 2));
      idle_after("rand_once");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sv32_page_walker.md
Name: sv32_page_walker

Overview:
- Hardware Sv32 page-table walker. It serves translation requests raised by TLB misses in the load/store path.
- It reads one or two PTEs through a single-outstanding memory read port.
- It returns a one-cycle translation result broadcast, carrying VPN, PPN, superpage flag, permissions and fault.
- TLB-miss queues wake on this broadcast. They use the busy flag to throttle further miss issue.

Parameters:
- PADDR_W, 32, physical address width of the memory read port. PPN is PADDR_W-12 bits wide.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_rqValid  in  1  walk request valid
- IN_rqVAddr  in  32  virtual address of the missing access
- OUT_rqReady  out  1  walker can accept a request this cycle
- IN_satpPPN  in  20  root page-table PPN (satp.PPN[19:0])
- IN_flush  in  1  abort the walk (sfence/branch flush)
- OUT_pwActive  out  1  walk in progress
- OUT_memValid  out  1  PTE read request valid
- OUT_memAddr  out  32  PTE physical byte address, word aligned
- IN_memReady  in  1  memory accepts the request
- IN_memRespValid  in  1  PTE data valid
- IN_memRespData  in  32  PTE
- OUT_resValid  out  1  result pulse, one cycle
- OUT_resVPN  out  20  VA[31:12] of the completed walk
- OUT_resPPN  out  20  translated PPN (0 on fault)
- OUT_resIsSuperPage  out  1  leaf found at level 1
- OUT_resPerm  out  8  PTE[7:0] (DAGUXWRV) of the leaf (0 on fault)
- OUT_resPageFault  out  1  walk ended in a page fault

Behaviour:
- Reset values:
  - state=IDLE.
  - OUT_memValid=0, OUT_resValid=0, OUT_pwActive=0.
  - Result data fields=0.
  - OUT_rqReady=1 the cycle after reset deasserts.
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, DROP.
- OUT_pwActive=(state!=IDLE). OUT_rqReady=(state==IDLE)&&!IN_flush.
- IDLE: on IN_rqValid&&OUT_rqReady, latch VA and go to REQ1.
- REQ1:
  - OUT_memValid=1.
  - OUT_memAddr={IN_satpPPN, VA[31:22], 2'b00}.
  - Address must be held stable until IN_memReady.
  - On IN_memReady, go to WAIT1.
- WAIT1: on IN_memRespValid, evaluate the PTE in this order:
  - PTE[0]==0, or PTE[2:1]==2'b10, or PTE[31:30]!=0: fault.
  - PTE[3]|PTE[1] (leaf): if PTE[19:10]!=0 it is a misaligned superpage and faults. Otherwise the result is superpage=1, PPN=PTE[29:10], perm=PTE[7:0].
  - Otherwise (pointer): latch base=PTE[29:10] and go to REQ2.
- REQ2: OUT_memAddr={base, VA[21:12], 2'b00}. Same handshake as REQ1, then go to WAIT2.
- WAIT2: same checks as WAIT1, except:
  - A pointer PTE (not a leaf) faults.
  - A leaf gives superpage=0 and PPN=PTE[29:10].
- Result timing:
  - OUT_resValid is registered and pulses in the cycle after the response is accepted; state is IDLE in that cycle.
  - A new request may be accepted during the result cycle.
  - Latency with zero-wait memory: superpage result 3 cycles after acceptance, 4K result 5 cycles after acceptance.
- Flush handling (IN_flush has priority over all progress):
  - REQ1/REQ2 with !IN_memReady: go to IDLE.
  - REQ1/REQ2 with IN_memReady in the same cycle: the request was issued, so go to DROP.
  - WAIT1/WAIT2 without IN_memRespValid: go to DROP.
  - WAIT1/WAIT2 with IN_memRespValid in the same cycle: go to IDLE. The response is discarded and no result is produced.
  - DROP: OUT_memValid=0. Wait for IN_memRespValid, discard it, go to IDLE. Further flushes have no extra effect.
  - IDLE: no effect.
- No result is ever emitted for a flushed walk.
- IN_memRespValid outside WAIT1/WAIT2/DROP is ignored; assert it never occurs.
- At most one memory request is outstanding.
- rst mid-walk: go to IDLE immediately. A late response arriving after reset is ignored.

Test Plan:
- Two-level walk:
  - Stimulus: satpPPN=0x00080, VA=0x40001234. Memory sees 0x00080400, reply 0x00024001. Memory then sees 0x00090004, reply 0x000400CF.
  - Required: resValid once, VPN=0x40001, PPN=0x00100, perm=0xCF, super=0, fault=0.
- Superpage: L1 reply 0x2000000F -> PPN=0x80000, super=1, fault=0, and exactly one memory request.
- Faults, each producing fault=1, PPN=0, perm=0:
  - Misaligned superpage: L1 reply 0x2000040F.
  - Invalid L1 PTE: reply 0x00000000, after one access.
  - Pointer at level 0: L2 reply 0x00024001.
  - Reserved W-only PTE: L1 reply 0x00000005.
- Backpressure: IN_memReady low 5 cycles in REQ1 -> memValid and memAddr constant for all 5 cycles, exactly one handshake, rqReady=0 throughout.
- Flush:
  - Flush in WAIT1, response arriving 3 cycles later -> DROP, no resValid, then IDLE.
  - A following request to VA=0x00400000 completes normally.
  - Flush in REQ2 with memReady=0 -> IDLE next cycle, no further memory request.
- Back-to-back: a second request presented in the result cycle is accepted. Both results appear in order, pwActive drops only for the result cycle.
